// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I instruction decode feeding a registered two-entry skid buffer.
// The decode is purely combinational on the incoming word. Only the buffered bundle leaves the stage.
module id_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [2:0]      out_f_op,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [1:0]      out_a_sel,
  output logic            out_b_sel,
  output logic            out_reg_we,
  output logic            out_mem_re,
  output logic            out_mem_we,
  output logic [2:0]      out_funct3,
  output logic            out_is_jal,
  output logic            out_is_jalr,
  output logic            out_is_branch,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  if (XLEN != 32 || DEPTH != 2) begin : g_bad_params
    $error("id_decode_stage supports only XLEN=32 and DEPTH=2");
  end

  // ALU operation codes shared with the execute stage
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Branch compare codes; F_NONE marks a non-branch
  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_BEQ  = 3'd1;
  localparam logic [2:0] F_BNE  = 3'd2;
  localparam logic [2:0] F_BLT  = 3'd3;
  localparam logic [2:0] F_BGE  = 3'd4;
  localparam logic [2:0] F_BLTU = 3'd5;
  localparam logic [2:0] F_BGEU = 3'd6;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef struct packed {
    logic [3:0]      alu_op;
    logic [2:0]      f_op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [1:0]      a_sel;
    logic            b_sel;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic [2:0]      funct3;
    logic            is_jal;
    logic            is_jalr;
    logic            is_branch;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1_f;
  logic [4:0]      rs2_f;
  logic [4:0]      rd_f;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_shamt;
  logic [3:0]      base_op;
  logic            dec_bad;
  bundle_t         dec;

  state_t  state_q, state_d;
  logic    in_ready_q, in_ready_d;
  bundle_t head_q, head_d;
  bundle_t tail_q, tail_d;
  logic    accept;
  logic    send;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];
  assign rd_f   = in_instr[11:7];

  // Every immediate takes its sign from instr[31]; shifts only ever use the 5-bit shamt,
  // so it is handed on zero-extended rather than carrying funct7 bits in the upper imm
  assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b     = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u     = {in_instr[31:12], 12'b0};
  assign imm_j     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_shamt = {27'b0, in_instr[24:20]};

  // ALU op implied by funct3 for the register and immediate arithmetic groups
  always_comb begin
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  // Full decode of the incoming word; an illegal word collapses to a harmless ADD bundle
  always_comb begin
    dec        = '0;
    dec_bad    = 1'b0;
    dec.pc     = in_pc;
    dec.funct3 = funct3;
    dec.alu_op = ALU_ADD;
    dec.f_op   = F_NONE;
    case (opcode)
      OPC_OP: begin
        dec.rs1    = rs1_f;
        dec.rs2    = rs2_f;
        dec.rd     = rd_f;
        dec.reg_we = 1'b1;
        dec.alu_op = base_op;
        if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
          dec.alu_op = ALU_SRA;
        end else if (funct7 != 7'b0) begin
          dec_bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.rs1    = rs1_f;
        dec.rd     = rd_f;
        dec.reg_we = 1'b1;
        dec.b_sel  = 1'b1;
        dec.imm    = imm_i;
        dec.alu_op = base_op;
        if (funct3 == 3'b001) begin
          dec.imm = imm_shamt;
          dec_bad = (funct7 != 7'b0);
        end else if (funct3 == 3'b101) begin
          dec.imm = imm_shamt;
          if (funct7 == FUNCT7_ALT) begin
            dec.alu_op = ALU_SRA;
          end else if (funct7 != 7'b0) begin
            dec_bad = 1'b1;
          end
        end
      end
      OPC_LUI: begin
        dec.rd     = rd_f;
        dec.reg_we = 1'b1;
        dec.a_sel  = 2'd2;
        dec.b_sel  = 1'b1;
        dec.imm    = imm_u;
      end
      OPC_AUIPC: begin
        dec.rd     = rd_f;
        dec.reg_we = 1'b1;
        dec.a_sel  = 2'd1;
        dec.b_sel  = 1'b1;
        dec.imm    = imm_u;
      end
      OPC_LOAD: begin
        dec.rs1    = rs1_f;
        dec.rd     = rd_f;
        dec.reg_we = 1'b1;
        dec.mem_re = 1'b1;
        dec.b_sel  = 1'b1;
        dec.imm    = imm_i;
      end
      OPC_STORE: begin
        dec.rs1    = rs1_f;
        dec.rs2    = rs2_f;
        dec.mem_we = 1'b1;
        dec.b_sel  = 1'b1;
        dec.imm    = imm_s;
      end
      OPC_JAL: begin
        dec.rd     = rd_f;
        dec.reg_we = 1'b1;
        dec.a_sel  = 2'd1;
        dec.b_sel  = 1'b1;
        dec.imm    = imm_j;
        dec.is_jal = 1'b1;
      end
      OPC_JALR: begin
        dec.rs1     = rs1_f;
        dec.rd      = rd_f;
        dec.reg_we  = 1'b1;
        dec.b_sel   = 1'b1;
        dec.imm     = imm_i;
        dec.is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        dec.rs1       = rs1_f;
        dec.rs2       = rs2_f;
        dec.alu_op    = ALU_SUB;
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        case (funct3)
          3'b000:  dec.f_op = F_BEQ;
          3'b001:  dec.f_op = F_BNE;
          3'b100:  dec.f_op = F_BLT;
          3'b101:  dec.f_op = F_BGE;
          3'b110:  dec.f_op = F_BLTU;
          3'b111:  dec.f_op = F_BGEU;
          default: dec_bad  = 1'b1;
        endcase
      end
      default: dec_bad = 1'b1;
    endcase
    if (dec_bad) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.funct3  = funct3;
      dec.alu_op  = ALU_ADD;
      dec.f_op    = F_NONE;
      dec.illegal = 1'b1;
    end
  end

  // Occupancy state and the registered ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next occupancy; flush beats any simultaneous accept or send
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          if (accept && !send) begin
            state_d = TWO;
          end else if (!accept && send) begin
            state_d = EMPTY;
          end
        end
        TWO:     if (send) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  // Handshake qualifiers derived from the current occupancy
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = in_ready_q;
    accept    = in_valid & in_ready_q;
    send      = out_valid & out_ready;
  end

  // Head always holds the oldest entry; tail only fills when the head is stuck
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (!flush) begin
      case (state_q)
        EMPTY: if (accept) head_d = dec;
        ONE: begin
          if (accept && send) begin
            head_d = dec;
          end else if (accept) begin
            tail_d = dec;
          end
        end
        TWO:     if (send) head_d = tail_q;
        default: ;
      endcase
    end
  end

  // Entry storage, cleared on reset so the outputs read zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign out_alu_op    = head_q.alu_op;
  assign out_f_op      = head_q.f_op;
  assign out_imm       = head_q.imm;
  assign out_rs1       = head_q.rs1;
  assign out_rs2       = head_q.rs2;
  assign out_rd        = head_q.rd;
  assign out_a_sel     = head_q.a_sel;
  assign out_b_sel     = head_q.b_sel;
  assign out_reg_we    = head_q.reg_we;
  assign out_mem_re    = head_q.mem_re;
  assign out_mem_we    = head_q.mem_we;
  assign out_funct3    = head_q.funct3;
  assign out_is_jal    = head_q.is_jal;
  assign out_is_jalr   = head_q.is_jalr;
  assign out_is_branch = head_q.is_branch;
  assign out_illegal   = head_q.illegal;
  assign out_pc        = head_q.pc;

endmodule
